// File: rtl/reg_file_mp.sv
// Multi-port register file: two write lanes, NUM_RD read ports and a per-register
// busy scoreboard. All state updates on the falling clock edge.
module reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int INIT_MODE = 1,
  parameter int READ_REG  = 1,
  parameter int BYPASS    = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] r_addr,
  output logic [NUM_RD*DATA_W-1:0] r_data,
  output logic [NUM_RD-1:0]        r_busy,
  input  logic [1:0]               w_en,
  input  logic [2*ADDR_W-1:0]      w_addr,
  input  logic [2*DATA_W-1:0]      w_data,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy, busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;

  logic [ADDR_W-1:0] wa [2];
  logic [DATA_W-1:0] wd [2];
  logic [ADDR_W-1:0] ra [NUM_RD];
  logic [DATA_W-1:0] rd_val [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rd_flat;
  logic [1:0]        w_ok;
  logic              set_ok;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    logic [DATA_W-1:0] one;
    logic [DATA_W-1:0] v;
    one = {{(DATA_W-1){1'b0}}, 1'b1};
    // Shifting by i >= DATA_W yields zero, which is the required pattern there.
    v = (INIT_MODE == 1) ? (one << i) : '0;
    if (ZERO_REG != 0 && i == 0) v = '0;
    return v;
  endfunction

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      wa[k]   = w_addr[k*ADDR_W +: ADDR_W];
      wd[k]   = w_data[k*DATA_W +: DATA_W];
      w_ok[k] = w_en[k] && !(ZERO_REG != 0 && wa[k] == '0);
    end
    for (int p = 0; p < NUM_RD; p++) ra[p] = r_addr[p*ADDR_W +: ADDR_W];
    set_ok = set_en && !(ZERO_REG != 0 && set_addr == '0);
  end

  // NOTE: the array is reset because the reset pattern is architecturally visible;
  // port 1 is applied last so its non-blocking update wins on an address clash.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= init_val(i);
    end else begin
      for (int k = 0; k < 2; k++)
        if (w_ok[k]) regs[wa[k]] <= wd[k];
    end
  end

  // Retiring writes clear, then a new issue sets, so set wins on the same address.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < 2; k++)
      if (w_en[k]) busy_nxt[wa[k]] = 1'b0;
    if (set_ok) busy_nxt[set_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      logic hit_clr, hit_set;
      rd_val[p] = regs[ra[p]];
      hit_clr   = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (BYPASS != 0 && w_en[k] && wa[k] == ra[p]) begin
          rd_val[p] = wd[k];
          hit_clr   = 1'b1;
        end
      end
      if (ZERO_REG != 0 && ra[p] == '0) rd_val[p] = '0;
      hit_set   = set_en && set_addr == ra[p];
      r_busy[p] = busy[ra[p]] && !(hit_clr && !hit_set);
      rd_flat[p*DATA_W +: DATA_W] = rd_val[p];
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [NUM_RD*DATA_W-1:0] rd_q;
    always_ff @(negedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= rd_flat;
    end
    assign r_data = rd_q;
  end else begin : g_rd_comb
    assign r_data = rd_flat;
  end

endmodule
